// File: rtl/mycpu_pkg.sv
// Shared constants for the decode stage: opcodes, widths, field positions.
package mycpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned OP_W   = 6;

  localparam logic [XLEN-1:0] RESET_PC = 32'hbfc00000;

  localparam logic [OP_W-1:0] OP_SPECIAL = 6'h00;
  localparam logic [OP_W-1:0] OP_J       = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE     = 6'h05;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RS_MSB  = 25;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_MSB  = 20;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_MSB  = 15;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IDX_MSB = 25;

  // Branch displacement relative to fetch's PC+4, which already sits on the delay slot.
  function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00} - 32'd4;
  endfunction

endpackage

// File: rtl/mycpu_regfile.sv
// 32x32 register file: two combinational read ports with write-through, one write port, $0 tied to zero.
module mycpu_regfile
  import mycpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr1,
  output logic [XLEN-1:0]   rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [XLEN-1:0]   rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Next register contents; writes to $0 are dropped.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) regs_d[waddr] = wdata;
  end

  // Register storage, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  assign rdata1 = (raddr1 == '0)                 ? '0    :
                  (we && (waddr == raddr1))      ? wdata : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0)                 ? '0    :
                  (we && (waddr == raddr2))      ? wdata : regs_q[raddr2];

endmodule

// File: rtl/mycpu_id_stage.sv
// Decode stage: holds the fetched PC, buffers the SRAM word across stalls,
// reads operands, resolves beq/bne/j and hands off to execute.
module mycpu_id_stage
  import mycpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = mycpu_pkg::RESET_PC
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fs_valid,
  input  logic [XLEN-1:0]   fs_pc,
  input  logic [XLEN-1:0]   inst_sram_rdata,
  input  logic              es_allowin,
  input  logic [REG_AW-1:0] es_dest,
  input  logic [REG_AW-1:0] ms_dest,
  input  logic              ws_we,
  input  logic [REG_AW-1:0] ws_waddr,
  input  logic [XLEN-1:0]   ws_wdata,
  output logic              ds_allowin,
  output logic              br_taken,
  output logic [XLEN-1:0]   br_offset,
  output logic              ds_to_es_valid,
  output logic [XLEN-1:0]   ds_pc,
  output logic [XLEN-1:0]   ds_inst,
  output logic [XLEN-1:0]   rs_value,
  output logic [XLEN-1:0]   rt_value,
  output logic [REG_AW-1:0] ds_dest
);

  logic            ds_valid_q, ds_valid_d;
  logic [XLEN-1:0] ds_pc_q, ds_pc_d;
  logic            first_cycle_q, first_cycle_d;
  logic            buf_valid_q, buf_valid_d;
  logic [XLEN-1:0] inst_buf_q, inst_buf_d;

  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] rs, rt, rd, dest;
  logic [15:0]       imm;
  logic [25:0]       idx;
  logic              is_j, is_beq, is_bne;
  logic              hazard, ds_ready_go, fire, cond;
  logic [XLEN-1:0]   pc_plus4, pc_plus8, jmp_target, off_raw;

  assign ds_inst = buf_valid_q ? inst_buf_q : inst_sram_rdata;
  assign ds_pc   = ds_pc_q;

  // Instruction field extraction and destination selection.
  always_comb begin
    op     = ds_inst[OP_MSB:OP_LSB];
    rs     = ds_inst[RS_MSB:RS_LSB];
    rt     = ds_inst[RT_MSB:RT_LSB];
    rd     = ds_inst[RD_MSB:RD_LSB];
    imm    = ds_inst[IMM_MSB:0];
    idx    = ds_inst[IDX_MSB:0];
    is_j   = (op == OP_J);
    is_beq = (op == OP_BEQ);
    is_bne = (op == OP_BNE);
    dest   = rt;
    if (op == OP_SPECIAL)             dest = rd;
    else if (is_j || is_beq || is_bne) dest = '0;
    ds_dest = ds_valid_q ? dest : '0;
  end

  mycpu_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs),
    .rdata1 (rs_value),
    .raddr2 (rt),
    .rdata2 (rt_value),
    .we     (ws_we),
    .waddr  (ws_waddr),
    .wdata  (ws_wdata)
  );

  // Conservative RAW check against EX/MEM destinations, then the handshake.
  always_comb begin
    hazard = ds_valid_q &&
             (((rs != '0) && ((rs == es_dest) || (rs == ms_dest))) ||
              ((rt != '0) && ((rt == es_dest) || (rt == ms_dest))));
    ds_ready_go    = !hazard;
    ds_to_es_valid = ds_valid_q && ds_ready_go;
    ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
    fire           = ds_to_es_valid && es_allowin;
  end

  // Branch resolution; offset is relative to fetch's PC+4 with fetch at the delay slot.
  always_comb begin
    pc_plus4   = ds_pc_q + 32'd4;
    pc_plus8   = ds_pc_q + 32'd8;
    jmp_target = {pc_plus4[31:28], idx, 2'b00};
    cond       = is_j || (is_beq && (rs_value == rt_value)) ||
                 (is_bne && (rs_value != rt_value));
    off_raw    = is_j ? (jmp_target - pc_plus8) : branch_offset(imm);
    br_taken   = fire && cond;
    br_offset  = br_taken ? off_raw : '0;
  end

  // Stage capture and stall buffering of the one-cycle SRAM data.
  always_comb begin
    ds_valid_d    = ds_valid_q;
    ds_pc_d       = ds_pc_q;
    first_cycle_d = 1'b0;
    buf_valid_d   = buf_valid_q;
    inst_buf_d    = inst_buf_q;
    if (ds_allowin) ds_valid_d = fs_valid;
    if (ds_allowin && fs_valid) begin
      ds_pc_d       = fs_pc;
      first_cycle_d = 1'b1;
      buf_valid_d   = 1'b0;
    end else if (ds_valid_q && first_cycle_q && !fire) begin
      inst_buf_d  = inst_sram_rdata;
      buf_valid_d = 1'b1;
    end
  end

  // Stage state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ds_valid_q    <= 1'b0;
      ds_pc_q       <= RESET_PC;
      first_cycle_q <= 1'b0;
      buf_valid_q   <= 1'b0;
      inst_buf_q    <= '0;
    end else begin
      ds_valid_q    <= ds_valid_d;
      ds_pc_q       <= ds_pc_d;
      first_cycle_q <= first_cycle_d;
      buf_valid_q   <= buf_valid_d;
      inst_buf_q    <= inst_buf_d;
    end
  end

endmodule

// File: tb/tb_mycpu_id_stage.sv
// Scoreboard bench for the decode stage: stimulus pushes expected hand-offs, a monitor checks each fire.
module tb_mycpu_id_stage;

  logic        clk;
  logic        rst;
  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] inst_sram_rdata;
  logic        es_allowin;
  logic [4:0]  es_dest, ms_dest;
  logic        ws_we;
  logic [4:0]  ws_waddr;
  logic [31:0] ws_wdata;
  logic        ds_allowin, br_taken, ds_to_es_valid;
  logic [31:0] br_offset, ds_pc, ds_inst, rs_value, rt_value;
  logic [4:0]  ds_dest;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  dest;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        taken;
    logic [31:0] off;
    logic [31:0] target;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  mycpu_id_stage dut (
    .clk             (clk),
    .rst             (rst),
    .fs_valid        (fs_valid),
    .fs_pc           (fs_pc),
    .inst_sram_rdata (inst_sram_rdata),
    .es_allowin      (es_allowin),
    .es_dest         (es_dest),
    .ms_dest         (ms_dest),
    .ws_we           (ws_we),
    .ws_waddr        (ws_waddr),
    .ws_wdata        (ws_wdata),
    .ds_allowin      (ds_allowin),
    .br_taken        (br_taken),
    .br_offset       (br_offset),
    .ds_to_es_valid  (ds_to_es_valid),
    .ds_pc           (ds_pc),
    .ds_inst         (ds_inst),
    .rs_value        (rs_value),
    .rt_value        (rt_value),
    .ds_dest         (ds_dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic [4:0] dest,
                              input logic [31:0] rsv, input logic [31:0] rtv, input logic taken,
                              input logic [31:0] off, input logic [31:0] target);
    exp_t e;
    e.pc = pc; e.inst = inst; e.dest = dest; e.rs = rsv; e.rt = rtv;
    e.taken = taken; e.off = off; e.target = target;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request cycle, then SRAM data appears in the following cycle.
  task automatic issue(input logic [31:0] pc, input logic [31:0] inst, input exp_t e);
    fs_valid = 1'b1;
    fs_pc    = pc;
    sb_q.push_back(e);
    tick();
    fs_valid        = 1'b0;
    inst_sram_rdata = inst;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    ws_we = 1'b1; ws_waddr = a; ws_wdata = d;
    tick();
    ws_we = 1'b0;
  endtask

  // Monitor: every hand-off to EX is matched against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (ds_to_es_valid && es_allowin) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_fire: got pc %h expected no hand-off", ds_pc);
        end else begin
          mon_e = sb_q.pop_front();
          check32("fire_pc", ds_pc, mon_e.pc);
          check32("fire_inst", ds_inst, mon_e.inst);
          check32("fire_dest", 32'(ds_dest), 32'(mon_e.dest));
          check32("fire_rs", rs_value, mon_e.rs);
          check32("fire_rt", rt_value, mon_e.rt);
          check32("fire_br_taken", 32'(br_taken), 32'(mon_e.taken));
          check32("fire_br_offset", br_offset, mon_e.off);
          if (mon_e.taken) check32("fire_next_pc", ds_pc + 32'd8 + br_offset, mon_e.target);
        end
      end else begin
        check32("idle_br_taken", 32'(br_taken), 32'd0);
        check32("idle_br_offset", br_offset, 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; fs_valid = 1'b0; fs_pc = '0; inst_sram_rdata = 32'h00221821;
    es_allowin = 1'b1; es_dest = '0; ms_dest = '0;
    ws_we = 1'b0; ws_waddr = '0; ws_wdata = '0;
    repeat (2) tick();
    rst = 1'b0;
    #2;
    check32("rst_ds_allowin", 32'(ds_allowin), 32'd1);
    check32("rst_br_taken", 32'(br_taken), 32'd0);
    check32("rst_br_offset", br_offset, 32'd0);
    check32("rst_ds_to_es_valid", 32'(ds_to_es_valid), 32'd0);
    check32("rst_ds_dest", 32'(ds_dest), 32'd0);
    check32("rst_ds_pc", ds_pc, 32'hbfc00000);
    tick();

    wr(5'd1, 32'd5);
    wr(5'd2, 32'd5);
    wr(5'd4, 32'd9);

    // addu $3,$1,$2
    issue(32'hbfc00000, 32'h00221821, mk(32'hbfc00000, 32'h00221821, 5'd3, 32'd5, 32'd5, 1'b0, 32'd0, 32'd0));
    tick();
    // beq $1,$2,+4 taken
    issue(32'hbfc00010, 32'h10220004, mk(32'hbfc00010, 32'h10220004, 5'd0, 32'd5, 32'd5, 1'b1, 32'h0000000c, 32'hbfc00024));
    tick();
    // bne $1,$2 with equal operands: not taken
    issue(32'hbfc00020, 32'h14220008, mk(32'hbfc00020, 32'h14220008, 5'd0, 32'd5, 32'd5, 1'b0, 32'd0, 32'd0));
    tick();
    // bne $1,$4,-2 taken backwards
    issue(32'hbfc00030, 32'h1424fffe, mk(32'hbfc00030, 32'h1424fffe, 5'd0, 32'd5, 32'd9, 1'b1, 32'hfffffff4, 32'hbfc0002c));
    tick();
    // j 0x100 -> 0xb0000400
    issue(32'hbfc00040, 32'h08000100, mk(32'hbfc00040, 32'h08000100, 5'd0, 32'd0, 32'd0, 1'b1, 32'hf04003b8, 32'hb0000400));
    tick();

    // EX backpressure for 3 cycles while SRAM data changes
    es_allowin = 1'b0;
    issue(32'hbfc00050, 32'h24850001, mk(32'hbfc00050, 32'h24850001, 5'd5, 32'd9, 32'd0, 1'b0, 32'd0, 32'd0));
    for (int i = 0; i < 3; i++) begin
      #2;
      check32("stall_ds_inst", ds_inst, 32'h24850001);
      check32("stall_ds_allowin", 32'(ds_allowin), 32'd0);
      check32("stall_valid", 32'(ds_to_es_valid), 32'd1);
      tick();
      inst_sram_rdata = 32'hdeadbeef;
    end
    es_allowin = 1'b1;
    tick();

    // RAW hazard on rs via es_dest, released with a same-cycle writeback
    es_dest = 5'd1;
    issue(32'hbfc00060, 32'h00223021, mk(32'hbfc00060, 32'h00223021, 5'd6, 32'd7, 32'd5, 1'b0, 32'd0, 32'd0));
    for (int i = 0; i < 2; i++) begin
      #2;
      check32("haz_es_valid", 32'(ds_to_es_valid), 32'd0);
      check32("haz_es_allowin", 32'(ds_allowin), 32'd0);
      tick();
      inst_sram_rdata = 32'hdeadbeef;
    end
    es_dest = 5'd0;
    ws_we = 1'b1; ws_waddr = 5'd1; ws_wdata = 32'd7;
    #2;
    check32("wt_rs_value", rs_value, 32'd7);
    tick();
    ws_we = 1'b0;

    // RAW hazard on rt via ms_dest
    ms_dest = 5'd2;
    issue(32'hbfc00070, 32'h00023821, mk(32'hbfc00070, 32'h00023821, 5'd7, 32'd0, 32'd5, 1'b0, 32'd0, 32'd0));
    #2;
    check32("haz_ms_valid", 32'(ds_to_es_valid), 32'd0);
    tick();
    ms_dest = 5'd0;
    tick();

    // Reset while an instruction is held by backpressure
    es_allowin = 1'b0;
    fs_valid = 1'b1; fs_pc = 32'hbfc00080;
    tick();
    fs_valid = 1'b0; inst_sram_rdata = 32'h00221821;
    #2;
    check32("pre_rst_valid", 32'(ds_to_es_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; es_allowin = 1'b1;
    #2;
    check32("midrst_valid", 32'(ds_to_es_valid), 32'd0);
    check32("midrst_allowin", 32'(ds_allowin), 32'd1);
    check32("midrst_dest", 32'(ds_dest), 32'd0);
    check32("midrst_rf_cleared", rs_value, 32'd0);
    tick();
    tick();

    check32("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
